// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - Pong game controller signal bundle (pause pin present under PONG_PAUSE_EN)
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic       sw1;
    logic       sw2;
    logic       miss_l;
    logic       miss_r;
`ifdef PONG_PAUSE_EN
    logic       pause;
`endif
    logic [9:0] paddle_l_y;
    logic [9:0] paddle_r_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       ball_hold;
    logic       ball_run;
    logic       serve_dir;
    logic       game_over;
    logic [2:0] state;

    modport master (
        output frame_tick, start, sw1, sw2, miss_l, miss_r,
`ifdef PONG_PAUSE_EN
        output pause,
`endif
        input  paddle_l_y, paddle_r_y, score_l, score_r,
        input  ball_hold, ball_run, serve_dir, game_over, state
    );

    modport slave (
        input  frame_tick, start, sw1, sw2, miss_l, miss_r,
`ifdef PONG_PAUSE_EN
        input  pause,
`endif
        output paddle_l_y, paddle_r_y, score_l, score_r,
        output ball_hold, ball_run, serve_dir, game_over, state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong match sequencer: match FSM, paddles, scores, ball gating
// Optional pause state is built in when PONG_PAUSE_EN is defined.
module pong_game_ctrl #(
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_STEP  = 4,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180
) (
    input  logic             clk,
    input  logic             reset,
    pong_game_ctrl_if.slave  bus
);
    localparam logic [10:0] Y_MAX    = 11'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] Y_STEP   = 11'(PADDLE_STEP);
    localparam logic [9:0]  Y_CENTRE = 10'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [8:0]  SERVE_N  = 9'(SERVE_FRAMES);
    localparam logic [8:0]  OVER_N   = 9'(OVER_FRAMES);
    localparam logic [3:0]  WIN_N    = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_OVER   = 3'd3,
        ST_PAUSED = 3'd4
    } state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_cnt, w_cnt_next;
    logic [3:0] r_score_l, w_score_l_next;
    logic [3:0] r_score_r, w_score_r_next;
    logic       r_serve_dir, w_serve_dir_next;
    logic [9:0] r_pad_l, w_pad_l_next;
    logic [9:0] r_pad_r, w_pad_r_next;
    logic       r_ball_hold, r_ball_run, r_game_over;
    logic [8:0] w_cnt_inc;
    logic [3:0] w_score_l_inc, w_score_r_inc;

    // 11-bit arithmetic so the saturation compare can never wrap
    function automatic logic [9:0] f_move(input logic [9:0] y, input logic up);
        logic [10:0] y_w;
        y_w = {1'b0, y};
        if (up)
            return (y_w < Y_STEP) ? 10'd0 : 10'(y_w - Y_STEP);
        else
            return ((y_w + Y_STEP) > Y_MAX) ? Y_MAX[9:0] : 10'(y_w + Y_STEP);
    endfunction

    assign w_cnt_inc     = {1'b0, r_cnt} + 9'd1;
    assign w_score_l_inc = r_score_l + 4'd1;
    assign w_score_r_inc = r_score_r + 4'd1;

    always_comb begin
        w_state_next     = r_state;
        w_score_l_next   = r_score_l;
        w_score_r_next   = r_score_r;
        w_serve_dir_next = r_serve_dir;
        w_pad_l_next     = r_pad_l;
        w_pad_r_next     = r_pad_r;
        w_cnt_next       = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next     = ST_SERVE;
                    w_score_l_next   = 4'd0;
                    w_score_r_next   = 4'd0;
                    w_serve_dir_next = 1'b1;
                end
            end
            ST_SERVE: begin
                if (bus.frame_tick && (w_cnt_inc == SERVE_N))
                    w_state_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.miss_l && bus.miss_r) begin
                    w_state_next = ST_SERVE;
                end else if (bus.miss_l) begin
                    w_score_r_next   = w_score_r_inc;
                    w_serve_dir_next = 1'b1;
                    w_state_next     = (w_score_r_inc == WIN_N) ? ST_OVER : ST_SERVE;
                end else if (bus.miss_r) begin
                    w_score_l_next   = w_score_l_inc;
                    w_serve_dir_next = 1'b0;
                    w_state_next     = (w_score_l_inc == WIN_N) ? ST_OVER : ST_SERVE;
`ifdef PONG_PAUSE_EN
                end else if (bus.pause) begin
                    w_state_next = ST_PAUSED;
`endif
                end
            end
            ST_OVER: begin
                if (bus.start) begin
                    w_state_next     = ST_SERVE;
                    w_score_l_next   = 4'd0;
                    w_score_r_next   = 4'd0;
                    w_serve_dir_next = 1'b1;
                end else if (bus.frame_tick && (w_cnt_inc == OVER_N)) begin
                    w_state_next = ST_IDLE;
                end
            end
`ifdef PONG_PAUSE_EN
            ST_PAUSED: begin
                if (bus.pause)
                    w_state_next = ST_PLAY;
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase

        // A tick that coincides with a transition is not counted in the new state
        if (w_state_next != r_state)
            w_cnt_next = 8'd0;
        else if (bus.frame_tick && ((r_state == ST_SERVE) || (r_state == ST_OVER)))
            w_cnt_next = w_cnt_inc[7:0];

        if (bus.frame_tick && ((r_state == ST_SERVE) || (r_state == ST_PLAY))) begin
            w_pad_l_next = f_move(r_pad_l, bus.sw1);
            w_pad_r_next = f_move(r_pad_r, bus.sw2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_serve_dir <= 1'b1;
            r_pad_l     <= Y_CENTRE;
            r_pad_r     <= Y_CENTRE;
            r_ball_hold <= 1'b1;
            r_ball_run  <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_score_l   <= w_score_l_next;
            r_score_r   <= w_score_r_next;
            r_serve_dir <= w_serve_dir_next;
            r_pad_l     <= w_pad_l_next;
            r_pad_r     <= w_pad_r_next;
            r_ball_hold <= (w_state_next == ST_IDLE) || (w_state_next == ST_SERVE) ||
                           (w_state_next == ST_OVER);
            r_ball_run  <= (w_state_next == ST_PLAY);
            r_game_over <= (w_state_next == ST_OVER);
        end
    end

    assign bus.state      = r_state;
    assign bus.paddle_l_y = r_pad_l;
    assign bus.paddle_r_y = r_pad_r;
    assign bus.score_l    = r_score_l;
    assign bus.score_r    = r_score_r;
    assign bus.serve_dir  = r_serve_dir;
    assign bus.ball_hold  = r_ball_hold;
    assign bus.ball_run   = r_ball_run;
    assign bus.game_over  = r_game_over;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed and random checks of pong_game_ctrl against a behavioural model
module tb_pong_game_ctrl;
    localparam int YMAX = 416;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    int m_state, m_cnt, m_sl, m_sr, m_dir, m_pl, m_pr;

    pong_game_ctrl_if bus();

    pong_game_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int move(input int y, input bit up);
        if (up) return (y < 4) ? 0 : y - 4;
        return (y + 4 > YMAX) ? YMAX : y + 4;
    endfunction

    task automatic model_step(input bit rst, input bit ft, input bit st, input bit s1,
                              input bit s2, input bit ml, input bit mr, input bit pz);
        int ns;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_sl = 0; m_sr = 0; m_dir = 1; m_pl = 208; m_pr = 208;
            return;
        end
        ns = m_state;
        case (m_state)
            0: if (st) begin ns = 1; m_sl = 0; m_sr = 0; m_dir = 1; end
            1: if (ft && m_cnt + 1 == 60) ns = 2;
            2: begin
                if (ml && mr) ns = 1;
                else if (ml) begin m_sr++; m_dir = 1; ns = (m_sr == 7) ? 3 : 1; end
                else if (mr) begin m_sl++; m_dir = 0; ns = (m_sl == 7) ? 3 : 1; end
`ifdef PONG_PAUSE_EN
                else if (pz) ns = 4;
`endif
            end
            3: if (st) begin ns = 1; m_sl = 0; m_sr = 0; m_dir = 1; end
               else if (ft && m_cnt + 1 == 180) ns = 0;
            4: if (pz) ns = 2;
            default: ns = 0;
        endcase
        if (ft && (m_state == 1 || m_state == 2)) begin
            m_pl = move(m_pl, s1);
            m_pr = move(m_pr, s2);
        end
        if (ns != m_state) m_cnt = 0;
        else if (ft && (m_state == 1 || m_state == 3)) m_cnt++;
        m_state = ns;
    endtask

    task automatic compare_all();
        check("state", int'(bus.state), m_state);
        check("paddle_l_y", int'(bus.paddle_l_y), m_pl);
        check("paddle_r_y", int'(bus.paddle_r_y), m_pr);
        check("score_l", int'(bus.score_l), m_sl);
        check("score_r", int'(bus.score_r), m_sr);
        check("serve_dir", int'(bus.serve_dir), m_dir);
        check("ball_hold", int'(bus.ball_hold), (m_state == 0 || m_state == 1 || m_state == 3) ? 1 : 0);
        check("ball_run", int'(bus.ball_run), (m_state == 2) ? 1 : 0);
        check("game_over", int'(bus.game_over), (m_state == 3) ? 1 : 0);
    endtask

    // inputs change just after the falling edge, outputs are compared at the next falling edge
    task automatic cyc(input bit rst, input bit ft, input bit st, input bit s1,
                       input bit s2, input bit ml, input bit mr, input bit pz);
        reset = rst; bus.frame_tick = ft; bus.start = st; bus.sw1 = s1; bus.sw2 = s2;
        bus.miss_l = ml; bus.miss_r = mr;
`ifdef PONG_PAUSE_EN
        bus.pause = pz;
`endif
        @(posedge clk);
        model_step(rst, ft, st, s1, s2, ml, mr, pz);
        @(negedge clk);
        compare_all();
    endtask

    task automatic serve_out();
        for (int i = 0; i < 60; i++) cyc(0, 1, 0, i[0], i[0], 0, 0, 0);
    endtask

    initial begin
        bus.frame_tick = 0; bus.start = 0; bus.sw1 = 0; bus.sw2 = 0;
        bus.miss_l = 0; bus.miss_r = 0;
`ifdef PONG_PAUSE_EN
        bus.pause = 0;
`endif
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_pad_l", int'(bus.paddle_l_y), 208);
        check("rst_state", int'(bus.state), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        check("serve_entry", int'(bus.state), 1);
        serve_out();
        check("play_entry", int'(bus.state), 2);
        check("play_run", int'(bus.ball_run), 1);

        for (int i = 0; i < 60; i++) begin
            cyc(0, 1, 0, 1, 0, 0, 0, 0);
            if (i == 51) begin
                check("pad_l_floor", int'(bus.paddle_l_y), 0);
                check("pad_r_ceiling", int'(bus.paddle_r_y), YMAX);
            end
        end
        check("pad_l_held", int'(bus.paddle_l_y), 0);
        check("pad_r_held", int'(bus.paddle_r_y), YMAX);

        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        check("miss_l_score_r", int'(bus.score_r), 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        check("serve_ignores_miss", int'(bus.score_l), 0);
        serve_out();
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        check("double_miss_state", int'(bus.state), 1);

        for (int p = 0; p < 7; p++) begin
            serve_out();
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
        end
        check("win_score_l", int'(bus.score_l), 7);
        check("win_state", int'(bus.state), 3);
        for (int i = 0; i < 180; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
        check("over_to_idle", int'(bus.state), 0);
        check("idle_keeps_score", int'(bus.score_l), 7);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        check("restart_score", int'(bus.score_l), 0);

`ifdef PONG_PAUSE_EN
        serve_out();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        check("paused_state", int'(bus.state), 4);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        check("paused_ignores_miss", int'(bus.score_r), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        check("unpause_state", int'(bus.state), 2);
`else
        serve_out();
`endif
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("midplay_reset_state", int'(bus.state), 0);
        check("midplay_reset_pad_r", int'(bus.paddle_r_y), 208);

        for (int i = 0; i < 15000; i++) begin
            cyc($urandom_range(0, 2999) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 39) == 0,
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 19) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-flow sequencer for the VGA Pong top level.
- Runs the match FSM (idle, serve, play, game over) and owns both paddle position registers, updated once per video frame from sw1/sw2.
- Keeps both score counters and gates the ball datapath through ball_hold and ball_run.
- Sits between the switch inputs, the ball/collision datapath (which supplies miss pulses) and the pixel renderer (which consumes paddle Y and scores).

Parameters:
- SCREEN_H, 480, visible lines; paddle Y range is 0..SCREEN_H-PADDLE_H.
- PADDLE_H, 64, paddle height in lines.
- PADDLE_STEP, 4, lines moved per frame_tick.
- WIN_SCORE, 7, points that end the match (1..15).
- SERVE_FRAMES, 60, frame_ticks spent in SERVE before the ball is released (1..255).
- OVER_FRAMES, 180, frame_ticks spent in OVER before returning to IDLE (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, at start of vblank.
- start  in  1  one-cycle pulse that starts a match.
- sw1  in  1  left paddle direction: 1 = up (Y decreases), 0 = down.
- sw2  in  1  right paddle direction, same encoding as sw1.
- miss_l  in  1  one-cycle pulse: ball passed the left edge.
- miss_r  in  1  one-cycle pulse: ball passed the right edge.
- paddle_l_y  out  10  left paddle top line.
- paddle_r_y  out  10  right paddle top line.
- score_l  out  4  left player score.
- score_r  out  4  right player score.
- ball_hold  out  1  level; ball datapath holds the ball at centre while 1.
- ball_run  out  1  level; ball datapath advances the ball while 1.
- serve_dir  out  1  launch direction: 0 = toward left, 1 = toward right.
- game_over  out  1  high in OVER.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, OVER=3, PAUSED=4.

Behaviour:
- All outputs are registered. Any event is visible on outputs on the clock edge after it is sampled.
- Reset (synchronous, any state, any cycle) produces:
  - state=IDLE;
  - paddle_l_y=paddle_r_y=(SCREEN_H-PADDLE_H)/2 (208 at defaults);
  - scores=0, serve_dir=1, ball_hold=1, ball_run=0, game_over=0;
  - frame counter=0.
- frame counter: 8 bits. Cleared on every state entry. Increments on frame_tick in SERVE and OVER only.
- IDLE:
  - ball_hold=1, ball_run=0; scores from the previous match are kept.
  - start -> SERVE; scores cleared, serve_dir=1.
- SERVE:
  - ball_hold=1, ball_run=0.
  - On the frame_tick that brings the counter to SERVE_FRAMES -> PLAY.
  - miss_l/miss_r ignored.
  - start ignored.
- PLAY:
  - ball_hold=0, ball_run=1.
  - miss_l alone -> score_r+1, serve_dir=1.
  - miss_r alone -> score_l+1, serve_dir=0.
  - After a point, if the incremented score equals WIN_SCORE -> OVER, else -> SERVE.
  - miss_l and miss_r in the same cycle -> no score change, serve_dir unchanged, -> SERVE.
- OVER:
  - game_over=1, ball_hold=1, ball_run=0; scores frozen.
  - start -> SERVE with scores cleared and serve_dir=1. start has priority over the counter.
  - Otherwise, on the frame_tick that brings the counter to OVER_FRAMES -> IDLE.
- Paddles:
  - Update only on frame_tick while state is SERVE or PLAY; frozen in all other states.
  - Moving up: Y=Y-PADDLE_STEP, saturating at 0 (if Y<PADDLE_STEP then 0).
  - Moving down: Y=Y+PADDLE_STEP, saturating at SCREEN_H-PADDLE_H.
  - The comparison is computed in 11 bits, so no wrap-around is possible.
  - Both paddles update independently in the same cycle.
- Paddle positions are not re-centred between points or matches; only reset re-centres them.
- frame_tick coincident with a state transition: the transition takes effect, and the counter restarts at 0 in the new state (the tick is not counted). A paddle update on that tick still applies if the old state was SERVE or PLAY.

Optional Feature:
- Macro: PONG_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit, one-cycle pulse) and state PAUSED.
  - pause in PLAY -> PAUSED: ball_run=0, ball_hold=0 (ball frozen in place), paddles frozen, misses ignored.
  - pause in PAUSED -> PLAY.
  - pause in any other state is ignored.
  - A miss coincident with pause in PLAY: the miss wins and pause is dropped.
- Undefined: no pause port; state value 4 is never produced.

Test Plan:
1. Reset -> state=0, paddle_l_y=paddle_r_y=208, scores 0, ball_hold=1, ball_run=0, game_over=0, serve_dir=1.
2. start, then 60 frame_ticks -> state=1 until the 60th tick; on the next cycle state=2, ball_run=1, ball_hold=0.
3. In PLAY, sw1=1 and sw2=0 for 60 ticks -> paddle_l_y hits 0 after 52 ticks and stays 0; paddle_r_y hits 416 after 52 ticks and stays 416.
4. In PLAY:
   - miss_l -> score_r=1, serve_dir=1, state=1 next cycle.
   - miss_r during SERVE -> scores unchanged.
   - miss_l and miss_r together in PLAY -> scores unchanged, state=1.
5. Drive 7 miss_r pulses across serves -> score_l=7, state=3, game_over=1. After 180 ticks -> state=0 with score_l=7 still held. start -> scores 0, state=1.
6. With PONG_PAUSE_EN: pause in PLAY -> state=4, ball_run=0; frame_ticks do not move paddles; miss_l ignored; second pause -> state=2. Also: reset asserted mid-PLAY -> all reset values on the next edge.
